// File: rtl/gray_rx.sv
// Purpose : receive a gray-coded count from another timing path, resynchronise,
//           decode to binary, report the increment and flag multi-bit jumps.
// Latency : gray_in change captured at edge N shows on bin_out/valid at edge N+SYNC_STAGES.
// Backpr. : none; enable=0 freezes every register and forces valid low.
//
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (dominates enable and err_clr)
//   enable   - advances the synchroniser and compare stage when high
//   gray_in  - incoming gray count
//   err_clr  - clears the sticky error flag on an enabled edge
//   bin_out  - registered binary decode of the synchronised gray value
//   delta    - (new binary - previous binary) mod 2^WIDTH, meaningful with valid
//   valid    - one-cycle pulse when the decoded value changed
//   err      - sticky flag: an update changed more than one gray bit
module gray_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] delta,
  output logic             valid,
  output logic             err
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] gprev_q, gprev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] dec_bin;
  logic             changed;
  logic             multi_bit;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    g_s       = sync_q[SYNC_STAGES-1];
    diff      = g_s ^ gprev_q;
    changed   = |diff;
    // Clearing the lowest set bit leaves something only if two or more bits differ.
    multi_bit = |(diff & (diff - WIDTH'(1)));
    dec_bin   = gray2bin(g_s);

    sync_d  = sync_q;
    gprev_d = gprev_q;
    bin_d   = bin_q;
    delta_d = delta_q;
    valid_d = 1'b0;     // also covers the disabled case: valid drops on that edge
    err_d   = err_q;

    if (enable) begin
      sync_d[0] = gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end

      if (changed) begin
        gprev_d = g_s;
        bin_d   = dec_bin;
        delta_d = dec_bin - bin_q;  // modular wrap handles 255->0 and decrements
        valid_d = 1'b1;
      end

      // A new violation outranks a coincident clear.
      if (changed && multi_bit) begin
        err_d = 1'b1;
      end else if (err_clr) begin
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      gprev_q <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      gprev_q <= gprev_d;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign delta   = delta_q;
  assign valid   = valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_gray_rx.sv
// Purpose : self-checking bench for gray_rx (WIDTH=8, SYNC_STAGES=2).
// Latency : expects updates SYNC_STAGES edges after capture.
// Backpr. : drives enable low in directed and random phases.
module tb_gray_rx;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] gray_in;
  logic         err_clr;
  logic [W-1:0] bin_out;
  logic [W-1:0] delta;
  logic         valid;
  logic         err;

  int checks   = 0;
  int failures = 0;

  gray_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .gray_in (gray_in),
    .err_clr (err_clr),
    .bin_out (bin_out),
    .delta   (delta),
    .valid   (valid),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // Inputs seen on each enabled edge since reset; the value being compared on
  // an edge is the one sampled S enabled edges earlier (zero before that).
  logic [W-1:0] samp[$];
  logic [W-1:0] m_prev, m_bin, m_delta;
  logic         m_valid, m_err;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] gs;
    logic [W-1:0] nb;
    logic         vio;
    if (rst) begin
      samp.delete();
      m_prev = '0; m_bin = '0; m_delta = '0; m_valid = 1'b0; m_err = 1'b0;
    end else if (!enable) begin
      m_valid = 1'b0;
    end else begin
      gs = (samp.size() >= S) ? samp[samp.size()-S] : '0;
      samp.push_back(gray_in);
      if (samp.size() > 8) void'(samp.pop_front());
      vio = 1'b0;
      if (gs != m_prev) begin
        nb      = g2b(gs);
        vio     = ($countones(gs ^ m_prev) > 1);
        m_delta = nb - m_bin;
        m_bin   = nb;
        m_prev  = gs;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (vio) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("model_bin", {24'd0, bin_out}, {24'd0, m_bin});
    chk("model_err", {31'd0, err}, {31'd0, m_err});
    if (m_valid) chk("model_delta", {24'd0, delta}, {24'd0, m_delta});
  end

  // ---------------- directed helpers (literal expectations) ----------------
  task automatic upd(input logic [W-1:0] g, input logic [W-1:0] eb,
                     input logic [W-1:0] ed, input logic ee, input string nm);
    gray_in = g;
    repeat (3) @(negedge clk);
    chk({nm, "_valid"}, {31'd0, valid}, 32'd1);
    chk({nm, "_bin"}, {24'd0, bin_out}, {24'd0, eb});
    chk({nm, "_delta"}, {24'd0, delta}, {24'd0, ed});
    chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
    @(negedge clk);
    chk({nm, "_pulse"}, {31'd0, valid}, 32'd0);
  endtask

  task automatic clear_err(input string nm);
    err_clr = 1'b1;
    @(negedge clk);
    chk(nm, {31'd0, err}, 32'd0);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] g_cur;
    rst = 1'b1; enable = 1'b1; err_clr = 1'b0; gray_in = 8'h55;

    // Reset held with a busy input
    repeat (3) begin
      @(negedge clk);
      chk("rst_bin", {24'd0, bin_out}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_delta", {24'd0, delta}, 32'd0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("first_valid", {31'd0, valid}, 32'd1);
    chk("first_bin", {24'd0, bin_out}, 32'h66);
    chk("first_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    clear_err("clr0");

    // Counting
    upd(8'h00, 8'h00, 8'h9A, 1'b1, "to_zero");
    clear_err("clr1");
    upd(8'h01, 8'd1, 8'd1, 1'b0, "cnt1");
    upd(8'h03, 8'd2, 8'd1, 1'b0, "cnt2");
    upd(8'h02, 8'd3, 8'd1, 1'b0, "cnt3");

    // Enable gating
    enable = 1'b0; gray_in = 8'h06;
    repeat (10) begin
      @(negedge clk);
      chk("gate_bin", {24'd0, bin_out}, 32'd3);
      chk("gate_valid", {31'd0, valid}, 32'd0);
    end
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("ungate_valid", {31'd0, valid}, 32'd1);
    chk("ungate_bin", {24'd0, bin_out}, 32'd4);
    chk("ungate_delta", {24'd0, delta}, 32'd1);
    @(negedge clk);
    upd(8'h07, 8'd5, 8'd1, 1'b0, "cnt5");

    // Reset mid-stream
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_bin", {24'd0, bin_out}, 32'd0);
    chk("mid_rst_delta", {24'd0, delta}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", {31'd0, valid}, 32'd1);
    chk("post_rst_bin", {24'd0, bin_out}, 32'd5);
    chk("post_rst_delta", {24'd0, delta}, 32'd5);
    chk("post_rst_err", {31'd0, err}, 32'd1);
    @(negedge clk);

    // Wrap-around
    upd(8'h81, 8'hFE, 8'hF9, 1'b1, "to_254");
    clear_err("clr2");
    upd(8'h80, 8'hFF, 8'd1, 1'b0, "wrap255");
    upd(8'h00, 8'h00, 8'd1, 1'b0, "wrap0");

    // Violation, sticky, clear, clear-vs-set
    upd(8'h03, 8'd2, 8'd2, 1'b1, "jump");
    upd(8'h02, 8'd3, 8'd1, 1'b1, "sticky");
    clear_err("clr3");
    gray_in = 8'h05; err_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("setwins_valid", {31'd0, valid}, 32'd1);
    chk("setwins_bin", {24'd0, bin_out}, 32'd6);
    chk("setwins_delta", {24'd0, delta}, 32'd3);
    chk("setwins_err", {31'd0, err}, 32'd1);
    err_clr = 1'b0;
    @(negedge clk);

    // Decrement by one
    upd(8'h07, 8'd5, 8'hFF, 1'b1, "decr");

    // Randomized phase, checked by the model
    g_cur = gray_in;
    for (int it = 0; it < 500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 75) g_cur = g_cur ^ (8'd1 << $urandom_range(0, 7));
      else if (r < 85) g_cur = 8'($urandom);
      gray_in = g_cur;
      enable  = ($urandom_range(0, 99) < 85);
      err_clr = ($urandom_range(0, 99) < 8);
      rst     = ($urandom_range(0, 99) < 2);
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    rst = 1'b0; enable = 1'b1; err_clr = 1'b0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
